// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush control for load-use, branch, MDU and fetch-wait hazards
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1D_i,
    input  logic [4:0]       rs2D_i,
    input  logic [4:0]       rdE_i,
    input  logic             regwriteE_i,
    input  logic             loadE_i,
    input  logic             pcsrcE_i,
    input  logic             mdu_startE_i,
    input  logic             imem_ready_i,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             stallE_o,
    output logic             flushD_o,
    output logic             flushE_o,
    output logic             mdu_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic {RUN, MDU_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MDU_LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e;
    logic             wait_st, mdu_go;

    assign load_use = loadE_i & regwriteE_i & (rdE_i != 5'd0) &
                      ((rdE_i == rs1D_i) | (rdE_i == rs2D_i));
    assign wait_st  = state_q == MDU_WAIT;
    // An MDU op only starts when no higher-priority hazard claims the cycle
    assign mdu_go   = !wait_st & !pcsrcE_i & !load_use & mdu_startE_i;

    // Prioritised hazard decode; MDU_WAIT holds EX and ignores every other hazard
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (wait_st) begin
            stall_f = cnt_q != 4'd0;
            stall_d = cnt_q != 4'd0;
            stall_e = cnt_q != 4'd0;
        end else if (pcsrcE_i) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (mdu_startE_i) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (!imem_ready_i) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held
    assign stallF_o    = stall_f & rst_i;
    assign stallD_o    = stall_d & rst_i;
    assign stallE_o    = stall_e & rst_i;
    assign flushD_o    = flush_d & rst_i;
    assign flushE_o    = flush_e & rst_i;
    assign mdu_busy_o  = wait_st & rst_i;
    assign stall_cnt_o = stall_cnt_q;

    // Next state: MDU wait countdown and saturating stall-cycle count
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (stallF_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        if (wait_st) begin
            state_d = (cnt_q == 4'd0) ? RUN : MDU_WAIT;
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end else if (mdu_go) begin
            state_d = MDU_WAIT;
            cnt_d   = LAT_M1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl (MDU_LATENCY=4, CNT_W=4)
module tb_hazard_stall_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] rs1D_i = '0, rs2D_i = '0, rdE_i = '0;
    logic       regwriteE_i = 1'b0, loadE_i = 1'b0, pcsrcE_i = 1'b0;
    logic       mdu_startE_i = 1'b0, imem_ready_i = 1'b1;
    logic       stallF_o, stallD_o, stallE_o, flushD_o, flushE_o, mdu_busy_o;
    logic [3:0] stall_cnt_o;

    typedef struct {
        logic       sf, sd, se, fd, fe, busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       m_busy = 1'b0;
    logic [3:0] m_cnt = '0;
    logic [3:0] m_stall = '0;

    hazard_stall_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rdE_i(rdE_i),
        .regwriteE_i(regwriteE_i), .loadE_i(loadE_i), .pcsrcE_i(pcsrcE_i),
        .mdu_startE_i(mdu_startE_i), .imem_ready_i(imem_ready_i),
        .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o),
        .flushD_o(flushD_o), .flushE_o(flushE_o), .mdu_busy_o(mdu_busy_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic lu();
        return loadE_i && regwriteE_i && rdE_i != 0 && (rdE_i == rs1D_i || rdE_i == rs2D_i);
    endfunction

    // One cycle: predict, compare mid-cycle, then advance the model at the rising edge
    task automatic cyc(input string tag);
        exp_t e, g;
        e = '{0, 0, 0, 0, 0, 0, 4'd0};
        if (rst_i) begin
            e.cnt = m_stall;
            if (m_busy) begin
                e.busy = 1;
                e.sf = m_cnt != 0; e.sd = m_cnt != 0; e.se = m_cnt != 0;
            end else if (pcsrcE_i) begin
                e.fd = 1; e.fe = 1;
            end else if (lu()) begin
                e.sf = 1; e.sd = 1; e.fe = 1;
            end else if (mdu_startE_i) begin
                e.sf = 1; e.sd = 1; e.se = 1;
            end else if (!imem_ready_i) begin
                e.sf = 1; e.fd = 1;
            end
        end
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        check({tag, ".stallF"}, 32'(stallF_o), 32'(g.sf));
        check({tag, ".stallD"}, 32'(stallD_o), 32'(g.sd));
        check({tag, ".stallE"}, 32'(stallE_o), 32'(g.se));
        check({tag, ".flushD"}, 32'(flushD_o), 32'(g.fd));
        check({tag, ".flushE"}, 32'(flushE_o), 32'(g.fe));
        check({tag, ".busy"}, 32'(mdu_busy_o), 32'(g.busy));
        check({tag, ".scnt"}, 32'(stall_cnt_o), 32'(g.cnt));
        @(posedge clk_i);
        if (!rst_i) begin
            m_busy = 0; m_cnt = 0; m_stall = 0;
        end else begin
            if (g.sf && m_stall != 4'hF) m_stall = m_stall + 1;
            if (m_busy) begin
                if (m_cnt == 0) m_busy = 0;
                else m_cnt = m_cnt - 1;
            end else if (!pcsrcE_i && !lu() && mdu_startE_i) begin
                m_busy = 1; m_cnt = 3;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        loadE_i = 0; regwriteE_i = 0; pcsrcE_i = 0; mdu_startE_i = 0; imem_ready_i = 1;
        rdE_i = 0; rs1D_i = 0; rs2D_i = 0;
    endtask

    initial begin
        @(negedge clk_i);
        cyc("reset");
        rst_i = 1;
        cyc("idle");
        loadE_i = 1; regwriteE_i = 1; rdE_i = 5; rs1D_i = 5; rs2D_i = 7;
        cyc("lu_rs1");
        idle(); rs1D_i = 5;
        cyc("lu_after");
        loadE_i = 1; regwriteE_i = 1; rdE_i = 9; rs1D_i = 1; rs2D_i = 9;
        cyc("lu_rs2");
        idle();
        loadE_i = 1; regwriteE_i = 1;
        cyc("ld_x0");
        loadE_i = 1; regwriteE_i = 1; rdE_i = 5; rs1D_i = 5; pcsrcE_i = 1;
        cyc("br_lu");
        idle(); mdu_startE_i = 1;
        cyc("mdu_start");
        idle(); pcsrcE_i = 1;
        cyc("mdu_w1");
        idle(); imem_ready_i = 0;
        cyc("mdu_w2");
        idle();
        cyc("mdu_w3");
        cyc("mdu_w0");
        cyc("mdu_done");
        mdu_startE_i = 1;
        cyc("rst_start");
        mdu_startE_i = 0;
        cyc("rst_w1");
        cyc("rst_w2");
        rst_i = 0;
        cyc("rst_mid");
        rst_i = 1;
        cyc("rst_rel");
        imem_ready_i = 0;
        for (int i = 0; i < 20; i++) cyc("imem_wait");
        imem_ready_i = 1;
        cyc("imem_sat");
        for (int i = 0; i < 40; i++) begin
            rdE_i = 5'($urandom_range(0, 3)); rs1D_i = 5'($urandom_range(0, 3));
            rs2D_i = 5'($urandom_range(0, 3)); loadE_i = 1'($urandom);
            regwriteE_i = 1'($urandom); pcsrcE_i = ($urandom_range(0, 4) == 0);
            mdu_startE_i = ($urandom_range(0, 5) == 0); imem_ready_i = ($urandom_range(0, 3) != 0);
            cyc("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
